// File: rtl/ppl_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, multiply FSM states, defaults.
package ppl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_LUI  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_MUL  = 4'b1011;

  localparam int          MUL_CYCLES     = 32;
  localparam logic [31:0] JAL_OFFSET_DEF = 32'd4;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ppl_exe_if.sv
// ID/EX -> EX/MEM signal bundle; the execute stage sits on the slave side.
interface ppl_exe_if;
  logic        exWriteReg;
  logic        exMem2Reg;
  logic        exWriteMem;
  logic        exJal;
  logic        exAluImm;
  logic        exShift;
  logic [3:0]  exAluC;
  logic [31:0] expc4;
  logic [31:0] exDataA;
  logic [31:0] exDataB;
  logic [31:0] exDataImm;
  logic [4:0]  exReg0;
  logic        exStall;
  logic        mWriteReg;
  logic        mMem2Reg;
  logic        mWriteMem;
  logic [31:0] mAluR;
  logic [31:0] mDataB;
  logic [4:0]  mReg;

  modport master (
    output exWriteReg, exMem2Reg, exWriteMem, exJal, exAluImm, exShift,
           exAluC, expc4, exDataA, exDataB, exDataImm, exReg0,
    input  exStall, mWriteReg, mMem2Reg, mWriteMem, mAluR, mDataB, mReg
  );

  modport slave (
    input  exWriteReg, exMem2Reg, exWriteMem, exJal, exAluImm, exShift,
           exAluC, expc4, exDataA, exDataB, exDataImm, exReg0,
    output exStall, mWriteReg, mMem2Reg, mWriteMem, mAluR, mDataB, mReg
  );
endinterface

// File: rtl/ppl_mul_iter.sv
// Iterative shift-add 32x32 unsigned multiplier (low 32 product bits).
// Only built when MUL_EN is defined.
`ifdef MUL_EN
module ppl_mul_iter
  import ppl_pkg::*;
#(
  parameter int CYCLES = MUL_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] prod_o
);
  localparam int CNT_W = $clog2(CYCLES);

  mul_state_e       state_q;
  logic [31:0]      mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MS_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        MS_IDLE: if (start_i) begin
          mcand_q  <= a_i;
          mplier_q <= b_i;
          acc_q    <= '0;
          cnt_q    <= '0;
          state_q  <= MS_BUSY;
        end
        MS_BUSY: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          // last iteration lands on the same edge that leaves BUSY
          if (cnt_q == CNT_W'(CYCLES - 1)) state_q <= MS_DONE;
        end
        MS_DONE: state_q <= MS_IDLE;
        default: state_q <= MS_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == MS_BUSY);
  assign done_o = (state_q == MS_DONE);
  assign prod_o = acc_q;
endmodule
`endif

// File: rtl/ppl_exe.sv
// Execute stage with integrated EX/MEM register. Define MUL_EN to build the
// iterative multiplier and its stall; otherwise opcode 1011 yields 0 in one cycle.
module ppl_exe
  import ppl_pkg::*;
#(
  parameter logic [31:0] JAL_OFFSET = JAL_OFFSET_DEF
) (
  input  logic     clk,
  input  logic     reset,
  ppl_exe_if.slave bus
);
  logic [31:0] opA, opB, alu_r, res;

  always_comb begin
    opA = bus.exShift  ? {27'b0, bus.exDataImm[10:6]} : bus.exDataA;
    opB = bus.exAluImm ? bus.exDataImm : bus.exDataB;
    case (bus.exAluC)
      ALU_ADD:  alu_r = opA + opB;
      ALU_SUB:  alu_r = opA - opB;
      ALU_AND:  alu_r = opA & opB;
      ALU_OR:   alu_r = opA | opB;
      ALU_XOR:  alu_r = opA ^ opB;
      ALU_LUI:  alu_r = opB << 16;
      ALU_SLL:  alu_r = opB << opA[4:0];
      ALU_SRL:  alu_r = opB >> opA[4:0];
      ALU_SRA:  alu_r = $unsigned($signed(opB) >>> opA[4:0]);
      ALU_SLT:  alu_r = {31'b0, $signed(opA) < $signed(opB)};
      ALU_SLTU: alu_r = {31'b0, opA < opB};
      default:  alu_r = '0;
    endcase
    res = bus.exJal ? bus.expc4 + JAL_OFFSET : alu_r;
  end

  logic        bubble, mul_fin;
  logic [31:0] mul_prod;

`ifdef MUL_EN
  logic mul_start, mul_busy, mul_done;

  // reset gates the start so a held mul opcode cannot raise the stall during reset
  assign mul_start = reset && (bus.exAluC == ALU_MUL) && !bus.exJal && !mul_busy && !mul_done;

  ppl_mul_iter #(.CYCLES(MUL_CYCLES)) u_mul (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (mul_start),
    .a_i     (opA),
    .b_i     (opB),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  assign bus.exStall = mul_start || mul_busy;
  assign bubble      = mul_start || mul_busy;
  assign mul_fin     = mul_done;
`else
  assign bus.exStall = 1'b0;
  assign bubble      = 1'b0;
  assign mul_fin     = 1'b0;
  assign mul_prod    = '0;
`endif

  logic        wr_d, m2r_d, wm_d, wr_q, m2r_q, wm_q;
  logic [31:0] alur_d, datab_d, alur_q, datab_q;
  logic [4:0]  reg_d, reg_q;

  always_comb begin
    wr_d    = bus.exWriteReg;
    m2r_d   = bus.exMem2Reg;
    wm_d    = bus.exWriteMem;
    alur_d  = res;
    datab_d = bus.exDataB;
    reg_d   = bus.exReg0;
    if (bubble) begin
      wr_d   = 1'b0;
      m2r_d  = 1'b0;
      wm_d   = 1'b0;
      alur_d = '0;
      reg_d  = '0;
    end else if (mul_fin) begin
      m2r_d  = 1'b0;
      wm_d   = 1'b0;
      alur_d = mul_prod;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      m2r_q   <= 1'b0;
      wm_q    <= 1'b0;
      alur_q  <= '0;
      datab_q <= '0;
      reg_q   <= '0;
    end else begin
      wr_q    <= wr_d;
      m2r_q   <= m2r_d;
      wm_q    <= wm_d;
      alur_q  <= alur_d;
      datab_q <= datab_d;
      reg_q   <= reg_d;
    end
  end

  assign bus.mWriteReg = wr_q;
  assign bus.mMem2Reg  = m2r_q;
  assign bus.mWriteMem = wm_q;
  assign bus.mAluR     = alur_q;
  assign bus.mDataB    = datab_q;
  assign bus.mReg      = reg_q;
endmodule

// File: tb/tb_ppl_exe.sv
// Directed bench for ppl_exe: vector table for single-cycle ops plus hand-written
// multiply / reset sequences (multiply sequences need MUL_EN defined).
module tb_ppl_exe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ppl_exe_if bus ();
  ppl_exe dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        jal, aimm, sh;
    logic [3:0]  c;
    logic [31:0] pc4, a, b, imm;
    logic        wr, m2r, wm;
    logic [4:0]  rg;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic jal, logic aimm, logic sh, logic [3:0] c,
                              logic [31:0] pc4, logic [31:0] a, logic [31:0] b,
                              logic [31:0] imm, logic wr, logic m2r, logic wm,
                              logic [4:0] rg, logic [31:0] exp);
    vec_t v;
    v.jal = jal; v.aimm = aimm; v.sh = sh; v.c = c; v.pc4 = pc4;
    v.a = a; v.b = b; v.imm = imm; v.wr = wr; v.m2r = m2r; v.wm = wm;
    v.rg = rg; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.exJal = v.jal; bus.exAluImm = v.aimm; bus.exShift = v.sh; bus.exAluC = v.c;
    bus.expc4 = v.pc4; bus.exDataA = v.a; bus.exDataB = v.b; bus.exDataImm = v.imm;
    bus.exWriteReg = v.wr; bus.exMem2Reg = v.m2r; bus.exWriteMem = v.wm; bus.exReg0 = v.rg;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_alur"},  bus.mAluR, 32'h0);
    chk({nm, "_datab"}, bus.mDataB, 32'h0);
    chk({nm, "_ctl"},   {29'b0, bus.mWriteReg, bus.mMem2Reg, bus.mWriteMem}, 32'h0);
    chk({nm, "_reg"},   {27'b0, bus.mReg}, 32'h0);
    chk({nm, "_stall"}, {31'b0, bus.exStall}, 32'h0);
  endtask

  task automatic nop();
    apply(mk(0,0,0,4'h0,0,0,0,0,0,0,0,5'd0,0));
  endtask

`ifdef MUL_EN
  task automatic do_mul(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rg, input logic [31:0] exp);
    int cnt = 0;
    int nbub = 0;
    apply(mk(0,0,0,4'hB,0,a,b,0,1,1,1,rg,0));
    #1;
    while (bus.exStall && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
      if (bus.mWriteReg || bus.mWriteMem || bus.mMem2Reg || bus.mReg != 0 || bus.mAluR != 0)
        nbub++;
    end
    chk({nm, "_stall_cycles"}, cnt, 33);
    chk({nm, "_bubbles"}, nbub, 0);
    @(posedge clk); #1;
    chk({nm, "_alur"},  bus.mAluR, exp);
    chk({nm, "_reg"},   {27'b0, bus.mReg}, {27'b0, rg});
    chk({nm, "_ctl"},   {29'b0, bus.mWriteReg, bus.mMem2Reg, bus.mWriteMem}, 32'h4);
    chk({nm, "_datab"}, bus.mDataB, b);
    nop();
  endtask
`endif

  initial begin
    // reset with arbitrary inputs, including the multiply opcode
    bus.exJal = 1'b0; bus.exAluImm = $urandom_range(0,1); bus.exShift = $urandom_range(0,1);
    bus.exAluC = 4'hB; bus.expc4 = $urandom; bus.exDataA = $urandom; bus.exDataB = $urandom;
    bus.exDataImm = $urandom; bus.exWriteReg = 1'b1; bus.exMem2Reg = 1'b1;
    bus.exWriteMem = 1'b1; bus.exReg0 = 5'd17;
    #3;
    chk_zero("rst_t0");
    @(posedge clk); #1;
    chk_zero("rst_edge");
    #1 reset = 1'b1;
    nop();

    vq.push_back(mk(0,0,0,4'h0,0,32'd5,32'd7,0,1,0,0,5'd3,32'd12));
    vq.push_back(mk(0,0,0,4'h1,0,32'd5,32'd7,0,1,0,0,5'd4,32'hFFFF_FFFE));
    vq.push_back(mk(0,0,0,4'h2,0,32'hF0F0_1234,32'h0FF0_5678,0,1,0,0,5'd5,32'h00F0_1230));
    vq.push_back(mk(0,0,0,4'h3,0,32'hF0F0_1234,32'h0FF0_5678,0,1,0,0,5'd5,32'hFFF0_567C));
    vq.push_back(mk(0,0,0,4'h4,0,32'hF0F0_1234,32'h0FF0_5678,0,1,0,0,5'd5,32'hFF00_444C));
    vq.push_back(mk(0,1,0,4'h5,0,32'h1234_5678,32'h0,32'h0000_ABCD,1,0,0,5'd6,32'hABCD_0000));
    vq.push_back(mk(0,0,1,4'h8,0,32'h0,32'h8000_0001,32'h0000_0100,1,0,0,5'd7,32'hF800_0000));
    vq.push_back(mk(0,0,1,4'h7,0,32'h0,32'h8000_0001,32'h0000_0100,1,0,0,5'd7,32'h0800_0000));
    vq.push_back(mk(0,0,1,4'h6,0,32'h0,32'h8000_0001,32'h0000_0100,1,0,0,5'd7,32'h0000_0010));
    vq.push_back(mk(0,0,0,4'h9,0,32'hFFFF_FFFF,32'd1,0,1,0,0,5'd8,32'd1));
    vq.push_back(mk(0,0,0,4'hA,0,32'hFFFF_FFFF,32'd1,0,1,0,0,5'd8,32'd0));
    vq.push_back(mk(1,0,0,4'h0,32'h0040_0008,32'd11,32'd22,0,1,0,0,5'd31,32'h0040_000C));
    vq.push_back(mk(1,0,0,4'hB,32'h0040_0008,32'd11,32'd22,0,1,0,0,5'd31,32'h0040_000C));
    vq.push_back(mk(0,0,0,4'hC,0,32'd9,32'd9,0,1,1,0,5'd10,32'd0));
    vq.push_back(mk(0,0,0,4'hF,0,32'd9,32'd9,0,0,0,1,5'd11,32'd0));
    vq.push_back(mk(0,1,0,4'h0,0,32'hFFFF_FFFF,32'h55,32'd1,1,1,1,5'd12,32'd0));

    foreach (vq[i]) begin
      apply(vq[i]);
      #1;
      chk($sformatf("v%0d_stall_pre", i), {31'b0, bus.exStall}, 32'h0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_alur", i), bus.mAluR, vq[i].exp);
      chk($sformatf("v%0d_ctl", i), {29'b0, bus.mWriteReg, bus.mMem2Reg, bus.mWriteMem},
          {29'b0, vq[i].wr, vq[i].m2r, vq[i].wm});
      chk($sformatf("v%0d_reg", i), {27'b0, bus.mReg}, {27'b0, vq[i].rg});
      chk($sformatf("v%0d_datab", i), bus.mDataB, vq[i].b);
    end

`ifdef MUL_EN
    do_mul("mul1", 32'h0001_0003, 32'h0000_0005, 5'd9, 32'h0005_000F);
    do_mul("mul2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001);
    @(posedge clk); #1;
    chk("after_mul_stall", {31'b0, bus.exStall}, 32'h0);

    // abort in the middle of BUSY
    apply(mk(0,0,0,4'hB,0,32'h0001_0003,32'h5,0,1,0,0,5'd9,0));
    repeat (11) @(posedge clk);
    #1;
    chk("mid_busy_stall", {31'b0, bus.exStall}, 32'h1);
    reset = 1'b0;
    #1;
    chk_zero("mid_rst");
    @(posedge clk); #1;
    chk_zero("mid_rst_edge");
    #1 reset = 1'b1;
    do_mul("mul3", 32'h0000_1234, 32'h0000_0010, 5'd21, 32'h0001_2340);
`else
    begin
      int nst = 0;
      apply(mk(0,0,0,4'hB,0,32'd3,32'd5,0,1,0,1,5'd9,0));
      #1;
      chk("ill_stall_pre", {31'b0, bus.exStall}, 32'h0);
      @(posedge clk); #1;
      chk("ill_alur", bus.mAluR, 32'h0);
      chk("ill_ctl", {29'b0, bus.mWriteReg, bus.mMem2Reg, bus.mWriteMem}, 32'h5);
      chk("ill_reg", {27'b0, bus.mReg}, 32'd9);
      repeat (4) begin
        @(posedge clk); #1;
        if (bus.exStall) nst++;
      end
      chk("ill_stall_hold", nst, 0);
      reset = 1'b0;
      #1;
      chk_zero("ill_rst");
      #1 reset = 1'b1;
    end
`endif

    nop();
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ppl_exe.md
Name: ppl_exe

Overview:
Execute stage that consumes the ID/EX pipeline register outputs (ex* control and data) and produces the EX/MEM register contents (m* outputs).
- Performs single-cycle ALU, shift, LUI, SLT and JAL return-address operations.
- Performs an iterative 32-cycle unsigned multiply.
- Asserts a stall back to fetch/decode while the multiply is in progress.
- Integrates the EX/MEM register, so every output is registered.

Parameters:
MUL_CYCLES, 32, number of shift-add iterations (fixed at 32 for 32-bit operands).
JAL_OFFSET, 4, constant added to expc4 to form the JAL link address.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
exWriteReg  input  1  register-file write enable of the EX instruction.
exMem2Reg  input  1  load (result comes from memory).
exWriteMem  input  1  store.
exJal  input  1  jump-and-link.
exAluImm  input  1  operand B = exDataImm.
exShift  input  1  operand A = exDataImm[10:6] zero-extended.
exAluC  input  4  ALU opcode.
expc4  input  32  PC+4 of the EX instruction.
exDataA  input  32  rs value.
exDataB  input  32  rt value.
exDataImm  input  32  extended immediate.
exReg0  input  5  destination register number.
exStall  output  1  high while the multiply is busy; ID/EX and earlier stages hold.
mWriteReg  output  1  registered.
mMem2Reg  output  1  registered.
mWriteMem  output  1  registered.
mAluR  output  32  registered result.
mDataB  output  32  registered exDataB (store data).
mReg  output  5  registered destination.

Behaviour:
- Reset (reset==0, asynchronous): all m* outputs = 0; exStall = 0; FSM = IDLE; counter, accumulator and multiplicand/multiplier shadow registers = 0.
- Operand muxing:
  - opA = exShift ? {27'b0, exDataImm[10:6]} : exDataA.
  - opB = exAluImm ? exDataImm : exDataB.
- exAluC codes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 lui (opB<<16).
  - 0110 sll (opB<<opA[4:0]), 0111 srl, 1000 sra.
  - 1001 slt (signed), 1010 sltu.
  - 1011 mul (low 32 bits of opA*opB).
  - All other codes give result 0.
  - Arithmetic wraps modulo 2^32; no overflow trap.
- Result = exJal ? expc4 + JAL_OFFSET : ALU result.
- Single-cycle ops (FSM IDLE, op != mul): on the rising edge, m* <= ex* / result. Latency 1 cycle. exStall = 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when exAluC==1011 and exJal==0. exStall goes high combinationally in that same cycle. The edge captures opA/opB into shadow registers, clears the accumulator and counter, and writes a bubble into EX/MEM (mWriteReg=mWriteMem=mMem2Reg=0, mReg=0, mAluR=0).
  - BUSY: each cycle, if multiplier bit0 then acc += multiplicand; multiplicand <<=1; multiplier >>=1; counter++. exStall=1; EX/MEM keeps receiving bubbles.
  - BUSY -> DONE when counter reaches MUL_CYCLES-1 (the final iteration is applied on that edge).
  - DONE: exStall=0. The edge writes mAluR=acc, mWriteReg=exWriteReg, mReg=exReg0, mDataB=exDataB, mMem2Reg=0, mWriteMem=0. Then -> IDLE.
  - Total: issue cycle plus 32 BUSY cycles stalled, then DONE; the result is visible on m* after 34 edges.
- ex* inputs are held stable by the upstream stall; the unit uses the shadow registers and ignores input changes during BUSY.
- Back-to-back mul: DONE returns to IDLE. The next mul, present the following cycle, restarts normally; there is no DONE->BUSY shortcut.
- Reset asserted mid-multiply: FSM aborts to IDLE and all outputs clear immediately; no partial result is written.

Optional Feature:
MUL_EN.
- Defined: multiply FSM, shadow registers and exStall logic as above.
- Undefined: code 1011 is an illegal opcode, handled as a single-cycle op producing result 0 with the control bits passed through unchanged; exStall is tied to 0 and the FSM is not built.

Decomposition:
- Shared package ppl_pkg: ALU opcode constants (ALU_ADD...ALU_MUL), FSM state encodings, JAL_OFFSET default.
- One sub-module, ppl_mul_iter: shift-add engine with start, busy and done signals and a 32-bit product. The top level keeps the ALU, muxing and EX/MEM register.

Test Plan:
1. Reset at t0 with random ex* inputs -> all m* = 0 and exStall = 0; after release and an add with A=5, B=7, WriteReg=1, Reg=3 -> next edge mAluR=12, mWriteReg=1, mReg=3.
2. Shift path: exShift=1, exDataImm[10:6]=4, exDataB=0x8000_0001, code sra -> mAluR=0xF800_0000. Same inputs with srl -> 0x0800_0000.
3. slt vs sltu: A=0xFFFF_FFFF, B=1 -> slt gives 1, sltu gives 0.
4. JAL: exJal=1, expc4=0x0040_0008 -> mAluR=0x0040_000C.
5. mul: A=0x0001_0003, B=0x0000_0005, Reg=9 -> exStall high for exactly 33 cycles, m* bubbles during the stall, then mAluR=0x0005_000F, mReg=9. Also run 0xFFFF_FFFF*0xFFFF_FFFF -> mAluR=1.
6. Reset pulsed low at BUSY cycle 10 -> outputs 0 and exStall=0 immediately; after release, a fresh mul completes correctly. Rebuild without MUL_EN -> exStall stays 0 and code 1011 gives mAluR=0 after 1 cycle.
